// File: rtl/midi_message_parser.sv
// MIDI channel-message parser: tracks running status and maintains the monophonic
// note/volume word, vibrato level and waveform select for the waveform generator.
module midi_message_parser #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] note_vol,
  output logic [7:0]  vibrato_level,
  output logic [1:0]  wave_select,
  output logic        note_event
);

  typedef enum logic [1:0] {StIdle, StWaitD1, StWaitD2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  run_status_q, run_status_d;
  logic [6:0]  d1_q, d1_d;
  logic [15:0] note_vol_q, note_vol_d;
  logic [7:0]  vibrato_q, vibrato_d;
  logic [1:0]  wave_q, wave_d;
  logic        note_event_q, note_event_d;

  logic       one_byte_msg;
  logic       exec;
  logic [6:0] ex_d1;
  logic [6:0] ex_d2;
  logic       note_off_hit;

  assign one_byte_msg = (run_status_q[7:4] == 4'hC) || (run_status_q[7:4] == 4'hD);
  assign note_off_hit = note_vol_q[15] && (ex_d1 == note_vol_q[14:8]);

  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    d1_d         = d1_q;
    note_vol_d   = note_vol_q;
    vibrato_d    = vibrato_q;
    wave_d       = wave_q;
    exec         = 1'b0;
    ex_d1        = d1_q;
    ex_d2        = rx_data[6:0];

    if (rx_valid) begin
      if (rx_data[7]) begin
        // Real-time bytes (F8-FF) pass through without touching any state.
        if (rx_data[7:3] == 5'b11111) begin
          state_d = state_q;
        end else if (rx_data[7:4] == 4'hF) begin
          run_status_d = 8'h00;
          state_d      = StIdle;
        end else begin
          run_status_d = rx_data;
          state_d      = StWaitD1;
        end
      end else begin
        case (state_q)
          StWaitD1: begin
            d1_d = rx_data[6:0];
            if (one_byte_msg) begin
              exec  = 1'b1;
              ex_d1 = rx_data[6:0];
            end else begin
              state_d = StWaitD2;
            end
          end
          StWaitD2: begin
            exec    = 1'b1;
            state_d = StWaitD1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    if (exec && (run_status_q[3:0] == MIDI_CHANNEL)) begin
      case (run_status_q[7:4])
        4'h9: begin
          if (ex_d2 != 7'd0) begin
            note_vol_d = {1'b1, ex_d1, ex_d2, 1'b0};
          end else if (note_off_hit) begin
            note_vol_d = {1'b0, note_vol_q[14:8], 8'h00};
          end
        end
        4'h8: begin
          if (note_off_hit) begin
            note_vol_d = {1'b0, note_vol_q[14:8], 8'h00};
          end
        end
        4'hE:    vibrato_d = {1'b0, ex_d2};
        4'hC:    wave_d    = ex_d1[1:0];
        default: wave_d    = wave_q;
      endcase
    end

    note_event_d = (note_vol_d != note_vol_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      run_status_q <= 8'h00;
      d1_q         <= 7'd0;
      note_vol_q   <= 16'h0000;
      vibrato_q    <= 8'h40;
      wave_q       <= 2'b00;
      note_event_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      d1_q         <= d1_d;
      note_vol_q   <= note_vol_d;
      vibrato_q    <= vibrato_d;
      wave_q       <= wave_d;
      note_event_q <= note_event_d;
    end
  end

  assign note_vol      = note_vol_q;
  assign vibrato_level = vibrato_q;
  assign wave_select   = wave_q;
  assign note_event    = note_event_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: byte sequences with hand-computed results.
module tb_midi_message_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] note_vol;
  logic [7:0]  vibrato_level;
  logic [1:0]  wave_select;
  logic        note_event;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int pulse_mark;

  midi_message_parser #(.MIDI_CHANNEL(4'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .note_vol     (note_vol),
    .vibrato_level(vibrato_level),
    .wave_select  (wave_select),
    .note_event   (note_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (note_event === 1'b1) pulses++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte for a single cycle; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("reset_note_vol", note_vol, 16'h0000);
    check("reset_vibrato", {8'h00, vibrato_level}, 16'h0040);
    check("reset_wave", {14'd0, wave_select}, 16'h0000);
    check("reset_event", {15'd0, note_event}, 16'h0000);

    // Basic note on / note off
    pulse_mark = pulses;
    send(8'h90); send(8'h3C); send(8'h64);
    check("t1_note_on", note_vol, 16'hBCC8);
    check("t1_on_event", {15'd0, note_event}, 16'h0001);
    idle(1);
    check("t1_event_one_cycle", {15'd0, note_event}, 16'h0000);
    send(8'h80); send(8'h3C); send(8'h00);
    check("t1_note_off", note_vol, 16'h3C00);
    check("t1_off_event", {15'd0, note_event}, 16'h0001);
    idle(2);
    check("t1_pulses", 16'(pulses - pulse_mark), 16'd2);

    // Running status, velocity-zero note off
    pulse_mark = pulses;
    send(8'h90); send(8'h40); send(8'h7F);
    check("t2_note_on", note_vol, 16'hC0FE);
    send(8'h40); send(8'h00);
    check("t2_vel0_off", note_vol, 16'h4000);
    idle(2);
    check("t2_pulses", 16'(pulses - pulse_mark), 16'd2);

    // Last-note priority and repeated identical note-on
    send(8'h90); send(8'h3C); send(8'h50);
    check("t3_first_on", note_vol, 16'hBCA0);
    send(8'h90); send(8'h3E); send(8'h50);
    check("t3_second_on", note_vol, 16'hBEA0);
    send(8'h3E); send(8'h50);
    check("t3_repeat_no_event", {15'd0, note_event}, 16'h0000);
    send(8'h80); send(8'h3C); send(8'h00);
    check("t3_stale_off", note_vol, 16'hBEA0);
    check("t3_stale_no_event", {15'd0, note_event}, 16'h0000);
    send(8'h80); send(8'h3E); send(8'h00);
    check("t3_real_off", note_vol, 16'h3E00);

    // Real-time bytes interleaved, pitch bend and program change
    send(8'hE0); send(8'hF8); send(8'h00); send(8'hFE); send(8'h50);
    check("t4_vibrato", {8'h00, vibrato_level}, 16'h0050);
    send(8'hC0); send(8'h02);
    check("t4_wave", {14'd0, wave_select}, 16'h0002);
    send(8'h01);
    check("t4_wave_running", {14'd0, wave_select}, 16'h0001);
    check("t4_note_hold", note_vol, 16'h3E00);

    // Channel filter, system common, orphan data
    pulse_mark = pulses;
    send(8'h91); send(8'h3C); send(8'h64);
    check("t5_other_chan", note_vol, 16'h3E00);
    send(8'hE1); send(8'h00); send(8'h10);
    check("t5_other_chan_bend", {8'h00, vibrato_level}, 16'h0050);
    send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7);
    check("t5_sysex", note_vol, 16'h3E00);
    send(8'h3C); send(8'h64);
    check("t5_orphan_data", note_vol, 16'h3E00);
    idle(2);
    check("t5_no_pulses", 16'(pulses - pulse_mark), 16'd0);

    // Asynchronous reset mid-message
    send(8'h90); send(8'h3C);
    reset = 1'b1;
    #1;
    check("t6_async_note_vol", note_vol, 16'h0000);
    check("t6_async_vibrato", {8'h00, vibrato_level}, 16'h0040);
    check("t6_async_wave", {14'd0, wave_select}, 16'h0000);
    idle(1);
    reset = 1'b0;
    idle(1);
    pulse_mark = pulses;
    send(8'h64);
    idle(1);
    check("t6_note_vol", note_vol, 16'h0000);
    check("t6_vibrato", {8'h00, vibrato_level}, 16'h0040);
    check("t6_wave", {14'd0, wave_select}, 16'h0000);
    idle(1);
    check("t6_no_pulse", 16'(pulses - pulse_mark), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
